// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg -- ID/EX pipeline register for the 5-stage RV32I core.
//
// Captures decode-stage control/data every clock. The hazard unit can hold
// the stage (StallE) or replace its contents with a bubble (FlushE). PCSrcE
// is resolved combinationally from the registered E fields and the live ALU
// flags. Two saturating counters record stall and bubble cycles for perf
// debug.
//
// Priority at each rising edge: rst > FlushE > StallE > normal load.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   StallE, FlushE      hazard-unit hold / bubble insert
//   *D inputs           decode-stage control, data and register addresses
//   ZeroE, LtE, LtuE    EX-stage ALU flags for the current EX instruction
//   *E outputs          registered copies of the D inputs, plus ValidE
//   PCSrcE              fetch redirect (combinational)
//   StallCnt, BubbleCnt saturating performance counters
//
// Optional feature: define BRANCH_FUNCT3_EN to decode the branch condition
// from funct3E (BEQ/BNE/BLT/BGE/BLTU/BGEU). When undefined, every branch
// uses BEQ semantics (take = ZeroE) and LtE/LtuE are ignored.
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int ALUCTRL_W = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 ValidD,
    input  logic                 RegWriteD,
    input  logic                 MemWriteD,
    input  logic                 JumpD,
    input  logic                 BranchD,
    input  logic                 ALUSrcD,
    input  logic [1:0]           ResultSrcD,
    input  logic [ALUCTRL_W-1:0] ALUControlD,
    input  logic [2:0]           funct3D,
    input  logic [XLEN-1:0]      PCD,
    input  logic [XLEN-1:0]      ImmExtD,
    input  logic [XLEN-1:0]      PCPlus4D,
    input  logic [XLEN-1:0]      RD1D,
    input  logic [XLEN-1:0]      RD2D,
    input  logic [REG_AW-1:0]    Rs1D,
    input  logic [REG_AW-1:0]    Rs2D,
    input  logic [REG_AW-1:0]    RdD,
    input  logic                 ZeroE,
    input  logic                 LtE,
    input  logic                 LtuE,
    output logic                 RegWriteE,
    output logic                 MemWriteE,
    output logic                 JumpE,
    output logic                 BranchE,
    output logic                 ALUSrcE,
    output logic                 ValidE,
    output logic [1:0]           ResultSrcE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic [2:0]           funct3E,
    output logic [XLEN-1:0]      PCE,
    output logic [XLEN-1:0]      ImmExtE,
    output logic [XLEN-1:0]      PCPlus4E,
    output logic [XLEN-1:0]      RD1E,
    output logic [XLEN-1:0]      RD2E,
    output logic [REG_AW-1:0]    Rs1E,
    output logic [REG_AW-1:0]    Rs2E,
    output logic [REG_AW-1:0]    RdE,
    output logic                 PCSrcE,
    output logic [CNT_W-1:0]     StallCnt,
    output logic [CNT_W-1:0]     BubbleCnt
);

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic                 mem_write;
        logic                 jump;
        logic                 branch;
        logic                 alu_src;
        logic [1:0]           result_src;
        logic [ALUCTRL_W-1:0] alu_control;
        logic [2:0]           funct3;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      imm_ext;
        logic [XLEN-1:0]      pc_plus4;
        logic [XLEN-1:0]      rd1;
        logic [XLEN-1:0]      rd2;
        logic [REG_AW-1:0]    rs1;
        logic [REG_AW-1:0]    rs2;
        logic [REG_AW-1:0]    rd;
    } stage_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    stage_t           stage_d, stage_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
    logic             take;

    always_comb begin
        stage_d      = stage_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (FlushE) begin
            // A bubble clears data fields too, so waveforms stay readable.
            stage_d = '0;
            if (bubble_cnt_q != CNT_MAX) bubble_cnt_d = bubble_cnt_q + 1'b1;
        end else if (StallE) begin
            if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
            stage_d.valid       = ValidD;
            stage_d.reg_write   = RegWriteD;
            stage_d.mem_write   = MemWriteD;
            stage_d.jump        = JumpD;
            stage_d.branch      = BranchD;
            stage_d.alu_src     = ALUSrcD;
            stage_d.result_src  = ResultSrcD;
            stage_d.alu_control = ALUControlD;
            stage_d.funct3      = funct3D;
            stage_d.pc          = PCD;
            stage_d.imm_ext     = ImmExtD;
            stage_d.pc_plus4    = PCPlus4D;
            stage_d.rd1         = RD1D;
            stage_d.rd2         = RD2D;
            stage_d.rs1         = Rs1D;
            stage_d.rs2         = Rs2D;
            stage_d.rd          = RdD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q      <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stage_q      <= stage_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

`ifdef BRANCH_FUNCT3_EN
    always_comb begin
        take = 1'b0;
        unique case (stage_q.funct3)
            3'b000:  take = ZeroE;
            3'b001:  take = ~ZeroE;
            3'b100:  take = LtE;
            3'b101:  take = ~LtE;
            3'b110:  take = LtuE;
            3'b111:  take = ~LtuE;
            default: take = 1'b0;
        endcase
    end
`else
    logic unused_lt_flags;
    assign unused_lt_flags = LtE ^ LtuE;
    assign take            = ZeroE;
`endif

    // Gated by ValidE so reset state and flushed bubbles never redirect.
    assign PCSrcE = stage_q.valid & (stage_q.jump | (stage_q.branch & take));

    assign ValidE      = stage_q.valid;
    assign RegWriteE   = stage_q.reg_write;
    assign MemWriteE   = stage_q.mem_write;
    assign JumpE       = stage_q.jump;
    assign BranchE     = stage_q.branch;
    assign ALUSrcE     = stage_q.alu_src;
    assign ResultSrcE  = stage_q.result_src;
    assign ALUControlE = stage_q.alu_control;
    assign funct3E     = stage_q.funct3;
    assign PCE         = stage_q.pc;
    assign ImmExtE     = stage_q.imm_ext;
    assign PCPlus4E    = stage_q.pc_plus4;
    assign RD1E        = stage_q.rd1;
    assign RD2E        = stage_q.rd2;
    assign Rs1E        = stage_q.rs1;
    assign Rs2E        = stage_q.rs2;
    assign RdE         = stage_q.rd;
    assign StallCnt    = stall_cnt_q;
    assign BubbleCnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg. The stimulus process drives one
// vector per cycle on the falling edge and queues the hand-computed state
// expected after the next rising edge. The monitor pops one entry per cycle
// shortly after the rising edge and compares the fields selected by its mask.
// A second instance with CNT_W=4 shares all inputs to exercise saturation.
module tb_id_ex_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, StallE, FlushE, ValidD;
    logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
    logic [1:0]  ResultSrcD;
    logic [3:0]  ALUControlD;
    logic [2:0]  funct3D;
    logic [31:0] PCD, ImmExtD, PCPlus4D, RD1D, RD2D;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        ZeroE, LtE, LtuE;

    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE, PCSrcE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic [2:0]  funct3E;
    logic [31:0] PCE, ImmExtE, PCPlus4E, RD1E, RD2E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [15:0] StallCnt, BubbleCnt;

    logic        s_RegWriteE, s_MemWriteE, s_JumpE, s_BranchE, s_ALUSrcE, s_ValidE, s_PCSrcE;
    logic [1:0]  s_ResultSrcE;
    logic [3:0]  s_ALUControlE;
    logic [2:0]  s_funct3E;
    logic [31:0] s_PCE, s_ImmExtE, s_PCPlus4E, s_RD1E, s_RD2E;
    logic [4:0]  s_Rs1E, s_Rs2E, s_RdE;
    logic [3:0]  s_StallCnt, s_BubbleCnt;

    id_ex_stage_reg dut (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
        .funct3D(funct3D), .PCD(PCD), .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D),
        .RD1D(RD1D), .RD2D(RD2D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ValidE(ValidE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .funct3E(funct3E), .PCE(PCE), .ImmExtE(ImmExtE),
        .PCPlus4E(PCPlus4E), .RD1E(RD1E), .RD2E(RD2E), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .PCSrcE(PCSrcE), .StallCnt(StallCnt), .BubbleCnt(BubbleCnt)
    );

    id_ex_stage_reg #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
        .funct3D(funct3D), .PCD(PCD), .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D),
        .RD1D(RD1D), .RD2D(RD2D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
        .RegWriteE(s_RegWriteE), .MemWriteE(s_MemWriteE), .JumpE(s_JumpE),
        .BranchE(s_BranchE), .ALUSrcE(s_ALUSrcE), .ValidE(s_ValidE),
        .ResultSrcE(s_ResultSrcE), .ALUControlE(s_ALUControlE), .funct3E(s_funct3E),
        .PCE(s_PCE), .ImmExtE(s_ImmExtE), .PCPlus4E(s_PCPlus4E), .RD1E(s_RD1E),
        .RD2E(s_RD2E), .Rs1E(s_Rs1E), .Rs2E(s_Rs2E), .RdE(s_RdE), .PCSrcE(s_PCSrcE),
        .StallCnt(s_StallCnt), .BubbleCnt(s_BubbleCnt)
    );

    localparam logic [8:0] M_PC = 9'h001, M_IMM = 9'h002, M_RD = 9'h004, M_RW = 9'h008,
                           M_V  = 9'h010, M_PS  = 9'h020, M_SC = 9'h040, M_BC = 9'h080,
                           M_SAT = 9'h100, M_ALL = 9'h1FF;

    typedef struct {
        string       name;
        logic [8:0]  mask;
        logic [31:0] pc, imm;
        logic [4:0]  rd;
        logic        rw, v, ps;
        logic [15:0] sc, bc;
        logic [3:0]  sat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: the DUT presents a new E-stage state after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.mask & M_PC)  chk({e.name, ".PCE"},       PCE,       e.pc);
                if (e.mask & M_IMM) chk({e.name, ".ImmExtE"},   ImmExtE,   e.imm);
                if (e.mask & M_RD)  chk({e.name, ".RdE"},       {27'd0, RdE},  {27'd0, e.rd});
                if (e.mask & M_RW)  chk({e.name, ".RegWriteE"}, {31'd0, RegWriteE}, {31'd0, e.rw});
                if (e.mask & M_V)   chk({e.name, ".ValidE"},    {31'd0, ValidE},    {31'd0, e.v});
                if (e.mask & M_PS)  chk({e.name, ".PCSrcE"},    {31'd0, PCSrcE},    {31'd0, e.ps});
                if (e.mask & M_SC)  chk({e.name, ".StallCnt"},  {16'd0, StallCnt},  {16'd0, e.sc});
                if (e.mask & M_BC)  chk({e.name, ".BubbleCnt"}, {16'd0, BubbleCnt}, {16'd0, e.bc});
                if (e.mask & M_SAT) chk({e.name, ".SatStallCnt"}, {28'd0, s_StallCnt}, {28'd0, e.sat});
            end
        end
    end

    task automatic push(input string nm, input logic [8:0] mask,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd,
                        input logic rw, input logic v, input logic ps,
                        input logic [15:0] sc, input logic [15:0] bc, input logic [3:0] sat);
        exp_t e;
        e.name = nm; e.mask = mask; e.pc = pc; e.imm = imm; e.rd = rd;
        e.rw = rw; e.v = v; e.ps = ps; e.sc = sc; e.bc = bc; e.sat = sat;
        exp_q.push_back(e);
    endtask

    // Advance to the falling edge and return all inputs to a quiet default.
    task automatic nxt();
        @(negedge clk);
        rst = 0; StallE = 0; FlushE = 0; ValidD = 0;
        RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0; ALUSrcD = 0;
        ResultSrcD = 0; ALUControlD = 0; funct3D = 0;
        PCD = 0; ImmExtD = 0; PCPlus4D = 0; RD1D = 0; RD2D = 0;
        Rs1D = 0; Rs2D = 0; RdD = 0; ZeroE = 0; LtE = 0; LtuE = 0;
    endtask

    task automatic all_d_nonzero();
        ValidD = 1; RegWriteD = 1; MemWriteD = 1; JumpD = 1; BranchD = 1; ALUSrcD = 1;
        ResultSrcD = 2'b11; ALUControlD = 4'hF; funct3D = 3'b111;
        PCD = 32'hDEAD_BEEF; ImmExtD = 32'h1234_5678; PCPlus4D = 32'hDEAD_BEF3;
        RD1D = 32'hA5A5_A5A5; RD2D = 32'h5A5A_5A5A; Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd31;
        ZeroE = 1;
    endtask

    initial begin
        logic exp_f3;
        int   budget;
        // Reset with every D input nonzero, stall and flush also asserted.
        for (int i = 0; i < 2; i++) begin
            nxt(); all_d_nonzero(); rst = 1; StallE = 1; FlushE = 1;
            push("reset", M_ALL, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end

        nxt(); PCD = 32'h40; ImmExtD = 32'hFFFF_FFF8; RdD = 5; RegWriteD = 1; ValidD = 1;
        push("pass", M_ALL, 32'h40, 32'hFFFF_FFF8, 5, 1, 1, 0, 0, 0, 0);

        nxt(); PCD = 32'h100; RdD = 7; RegWriteD = 1; ValidD = 1;
        push("load100", M_PC | M_RD | M_RW | M_V, 32'h100, 0, 7, 1, 1, 0, 0, 0, 0);

        for (int i = 1; i <= 3; i++) begin
            nxt(); StallE = 1; PCD = 32'h200; RdD = 9; RegWriteD = 1; ValidD = 1;
            push("stall", M_PC | M_RD | M_RW | M_V | M_SC | M_BC | M_SAT,
                 32'h100, 0, 7, 1, 1, 0, 16'(i), 0, 4'(i));
        end

        nxt(); StallE = 1; FlushE = 1; PCD = 32'h200; RdD = 9; RegWriteD = 1; ValidD = 1;
        push("stall_flush", M_PC | M_RD | M_RW | M_V | M_PS | M_SC | M_BC,
             0, 0, 0, 0, 0, 0, 3, 1, 0);

        nxt(); BranchD = 1; ValidD = 1; funct3D = 3'b000; PCD = 32'h300; ZeroE = 1;
        push("beq_taken", M_PC | M_V | M_PS | M_SC | M_BC, 32'h300, 0, 0, 0, 1, 1, 3, 1, 0);

        nxt(); BranchD = 1; ValidD = 1; funct3D = 3'b000; PCD = 32'h304; ZeroE = 1; FlushE = 1;
        push("beq_flushed", M_PC | M_V | M_PS | M_BC, 0, 0, 0, 0, 0, 0, 3, 2, 0);

        nxt(); JumpD = 1; ValidD = 1; ZeroE = 0;
        push("jump", M_V | M_PS, 0, 0, 0, 0, 1, 1, 0, 0, 0);

        nxt(); BranchD = 1; ValidD = 1; funct3D = 3'b000; ZeroE = 0;
        push("beq_not_taken", M_PS, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        nxt(); JumpD = 1; ValidD = 0; ZeroE = 1;
        push("jump_invalid", M_V | M_PS, 0, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef BRANCH_FUNCT3_EN
        exp_f3 = 1'b1;
`else
        exp_f3 = 1'b0;
`endif
        nxt(); BranchD = 1; ValidD = 1; funct3D = 3'b101; ZeroE = 0; LtE = 0;
        push("bge_f3", M_PS, 0, 0, 0, 0, 0, exp_f3, 0, 0, 0);

        // Reset in the middle of a stall clears stage and counters.
        nxt(); all_d_nonzero(); rst = 1; StallE = 1;
        push("reset_mid_stall", M_ALL, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 1; i <= 20; i++) begin
            nxt(); StallE = 1; PCD = 32'(i); ValidD = 1;
            push("saturate", M_PC | M_V | M_SC | M_SAT, 0, 0, 0, 0, 0, 0, 16'(i), 0,
                 (i > 15) ? 4'd15 : 4'(i));
        end

        nxt();
        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Parametrised ID/EX pipeline register for the 5-stage RV32I core.
- Captures decode-stage control and data on each clock.
- Supports hazard-unit stall (hold) and flush (bubble insert), and carries a valid bit plus source-register addresses for forwarding.
- Resolves PCSrcE combinationally in the same EX cycle, and keeps saturating bubble/stall counters for performance debug.

Parameters:
XLEN, 32, datapath width of PC, immediate, PC+4 and operand fields
REG_AW, 5, register address width (Rs1/Rs2/Rd)
ALUCTRL_W, 4, ALU control field width
CNT_W, 16, width of the stall and bubble performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; one clock; reset is synchronous and active-high
StallE  in  1  hold all E-stage registers
FlushE  in  1  load bubble (clear control, ValidE=0)
ValidD  in  1  decode slot holds a real instruction
RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  decode control
ResultSrcD  in  2  result mux select
ALUControlD  in  ALUCTRL_W  ALU operation
funct3D  in  3  branch/load-store sub-op
PCD, ImmExtD, PCPlus4D, RD1D, RD2D  in  XLEN each  decode data
Rs1D, Rs2D, RdD  in  REG_AW each  register addresses
ZeroE, LtE, LtuE  in  1 each  EX-stage ALU flags (same cycle)
RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE  out  1 each  registered control
ResultSrcE  out  2;  ALUControlE  out  ALUCTRL_W;  funct3E  out  3
PCE, ImmExtE, PCPlus4E, RD1E, RD2E  out  XLEN each
Rs1E, Rs2E, RdE  out  REG_AW each
PCSrcE  out  1  redirect fetch (combinational)
StallCnt, BubbleCnt  out  CNT_W each  saturating counters

Behaviour:
- Reset (rst=1 at posedge): every registered output is 0; ValidE=0; both counters are 0. Reset overrides StallE/FlushE. Reset mid-stall clears the stage.
- Priority at each posedge: rst > FlushE > StallE > normal load.
- Normal load: all E outputs take their D inputs after one cycle of latency; ValidE<=ValidD.
- Flush:
  - RegWriteE, MemWriteE, JumpE, BranchE, ValidE <= 0.
  - ResultSrcE, ALUControlE, funct3E, RdE, Rs1E, Rs2E <= 0.
  - Data fields (PC/Imm/RD) also <= 0 to keep waveforms clean.
- Stall without flush: all registers hold their value.
- FlushE and StallE together: flush wins, giving a bubble.
- PCSrcE = ValidE & (JumpE | (BranchE & take)). It is combinational from registered E fields and the live flags, with no extra register stage.
  - take = ZeroE (BEQ semantics) unless the optional feature is enabled.
  - PCSrcE is 0 whenever ValidE=0. This covers reset and flushed bubbles.
- StallCnt increments on each posedge with StallE=1 and FlushE=0. BubbleCnt increments on each posedge with FlushE=1. Both saturate at 2^CNT_W-1 and do not wrap. rst clears them.
- No combinational path from any D input to any E output.

Optional Feature:
- Macro BRANCH_FUNCT3_EN.
- Defined: take is decoded from funct3E:
  - 000 ZeroE; 001 !ZeroE
  - 100 LtE; 101 !LtE
  - 110 LtuE; 111 !LtuE
  - 010/011 give 0
- Undefined: take = ZeroE regardless of funct3E; LtE/LtuE are unused.

Test Plan:
- Reset: drive rst=1 with all D inputs nonzero for 2 clocks -> all E outputs 0, ValidE=0, PCSrcE=0, counters 0.
- Pass-through: PCD=0x0000_0040, ImmExtD=0xFFFF_FFF8, RdD=5, RegWriteD=1, ValidD=1 -> next cycle PCE=0x40, ImmExtE=0xFFFFFFF8, RdE=5, RegWriteE=1, ValidE=1.
- Stall then flush: load PCD=0x100, then hold StallE=1 for 3 clocks while PCD=0x200 -> PCE stays 0x100 and StallCnt=3. Then assert StallE=1 and FlushE=1 together -> RegWriteE=0, ValidE=0, BubbleCnt=1, StallCnt stays 3.
- Branch resolution:
  - BranchD=1, ValidD=1, funct3D=000, then ZeroE=1 in EX -> PCSrcE=1 in that same cycle.
  - Same setup but flushed -> PCSrcE=0.
  - JumpD=1 with ZeroE=0 -> PCSrcE=1.
- BRANCH_FUNCT3_EN defined, funct3=101, LtE=0 -> PCSrcE=1. With the macro undefined, funct3=101, ZeroE=0 -> PCSrcE=0.
- Saturation: CNT_W=4, hold StallE=1 for 20 clocks -> StallCnt=15 and stays 15.
